// File: rtl/pad_in_filter_pkg.sv
// Shared types and field positions for the pad input filter.
// Optional macro PAD_IN_FILTER_TIMESTAMP_EN adds the event timestamp registers.
package pad_in_filter_pkg;

  localparam int unsigned TS_W       = 16;
  localparam int unsigned CFG_DW     = 16;
  localparam int unsigned FILT_W_MAX = 8;
  localparam int unsigned EDGE_LSB   = 8;
  localparam int unsigned EDGE_MSB   = 9;
  localparam int unsigned IRQ_EN_BIT = 10;

  // Number of read-only addresses above N_IO (last one in use is N_IO + EXTRA_ADDRS).
`ifdef PAD_IN_FILTER_TIMESTAMP_EN
  localparam int unsigned EXTRA_ADDRS = 1;
`else
  localparam int unsigned EXTRA_ADDRS = 0;
`endif

  typedef enum logic [1:0] {
    EdgeNone = 2'b00,
    EdgeRise = 2'b01,
    EdgeFall = 2'b10,
    EdgeBoth = 2'b11
  } edge_mode_e;

  typedef struct packed {
    logic                  irq_en;
    edge_mode_e            edge_mode;
    logic [FILT_W_MAX-1:0] filt_len;
  } cfg_t;

  // Register image as seen on the config port; reserved bits read 0.
  function automatic logic [CFG_DW-1:0] cfg_pack(cfg_t c);
    logic [CFG_DW-1:0] r;
    r                     = '0;
    r[FILT_W_MAX-1:0]     = c.filt_len;
    r[EDGE_MSB:EDGE_LSB]  = c.edge_mode;
    r[IRQ_EN_BIT]         = c.irq_en;
    return r;
  endfunction

endpackage

// File: rtl/pad_in_filter_if.sv
// Config register port: request with no backpressure, response one cycle later.
interface pad_in_filter_if #(
  parameter int unsigned AW = 6
);
  logic          cfg_valid;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [15:0]   cfg_wdata;
  logic          cfg_rvalid;
  logic [15:0]   cfg_rdata;
  logic          cfg_err;

  modport master (
    output cfg_valid, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rvalid, cfg_rdata, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rvalid, cfg_rdata, cfg_err
  );
endinterface

// File: rtl/pad_in_filter_ch.sv
// One pad: 2-flop synchroniser, deglitch counter, edge detect and sticky event.
module pad_in_filter_ch
  import pad_in_filter_pkg::*;
#(
  parameter int unsigned FILT_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  input  cfg_t cfg_i,
  input  logic cnt_clr_i,
  input  logic evt_clr_i,
  output logic pad_o,
  output logic evt_o,
  output logic evt_set_o
);

  logic              s1_q, s2_q;
  logic              lvl_q, lvl_d;
  logic              prev_q;
  logic              evt_q, evt_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic [FILT_W-1:0] len;

  assign len = cfg_i.filt_len[FILT_W-1:0];

  // Deglitch: a new level must be held for len+1 samples of s2 before it is taken.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      // A config write restarts qualification under the new length.
      cnt_d = '0;
    end else if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == len) begin
      lvl_d = s2_q;
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Edge detect on the filtered level; set beats a same-cycle clear.
  always_comb begin
    evt_set_o = 1'b0;
    unique case (cfg_i.edge_mode)
      EdgeNone: evt_set_o = 1'b0;
      EdgeRise: evt_set_o = lvl_q & ~prev_q;
      EdgeFall: evt_set_o = ~lvl_q & prev_q;
      EdgeBoth: evt_set_o = lvl_q ^ prev_q;
    endcase
    evt_d = evt_set_o | (evt_q & ~evt_clr_i);
  end

  // Pad state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= pad_i;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
      evt_q  <= evt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pad_o = lvl_q;
  assign evt_o = evt_q;

endmodule

// File: rtl/pad_in_filter.sv
// Pad input filter: per-pad sync/deglitch/edge events, config register file and irq.
// Define PAD_IN_FILTER_TIMESTAMP_EN to add the event timestamp (addr N_IO) and
// event pad index (addr N_IO+1) read-only registers.
module pad_in_filter
  import pad_in_filter_pkg::*;
#(
  parameter int unsigned N_IO   = 50,
  parameter int unsigned FILT_W = 8,
  parameter int unsigned AW     = $clog2(N_IO + 1 + EXTRA_ADDRS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_IO-1:0] pad_in_i,
  output logic [N_IO-1:0] pad_in_o,
  output logic [N_IO-1:0] evt_o,
  input  logic [N_IO-1:0] evt_clr_i,
  output logic            irq_o,
  pad_in_filter_if.slave  cfg
);

  localparam logic [AW-1:0]         N_IO_A   = AW'(N_IO);
  localparam logic [FILT_W_MAX-1:0] LEN_MASK = FILT_W_MAX'((1 << FILT_W) - 1);

  cfg_t              cfg_q [N_IO];
  cfg_t              wr_cfg, rd_cfg;
  logic [N_IO-1:0]   wr_sel, evt_set, irq_en;
  logic              rvalid_q, err_q, err_d;
  logic [CFG_DW-1:0] rdata_q, rdata_d;
  logic              unused_wdata;

  assign unused_wdata = ^cfg.cfg_wdata[CFG_DW-1:IRQ_EN_BIT+1];

  // Decode the write data and the per-pad write strobes; read mux of the register file.
  always_comb begin
    wr_cfg.filt_len  = cfg.cfg_wdata[FILT_W_MAX-1:0] & LEN_MASK;
    wr_cfg.edge_mode = edge_mode_e'(cfg.cfg_wdata[EDGE_MSB:EDGE_LSB]);
    wr_cfg.irq_en    = cfg.cfg_wdata[IRQ_EN_BIT];
    rd_cfg           = '0;
    for (int i = 0; i < N_IO; i++) begin
      wr_sel[i] = cfg.cfg_valid & cfg.cfg_we & (cfg.cfg_addr == AW'(i));
      if (cfg.cfg_addr == AW'(i)) rd_cfg = cfg_q[i];
    end
  end

  // Config register file.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_IO; i++) cfg_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_IO; i++) if (wr_sel[i]) cfg_q[i] <= wr_cfg;
    end
  end

`ifdef PAD_IN_FILTER_TIMESTAMP_EN
  localparam int unsigned IDX_W = (N_IO > 1) ? $clog2(N_IO) : 1;

  logic [TS_W-1:0]  ts_cnt_q, ts_q;
  logic [IDX_W-1:0] ts_idx_q, idx_d;

  // Lowest-index pad raising an event this cycle.
  always_comb begin
    idx_d = '0;
    for (int i = N_IO - 1; i >= 0; i--) if (evt_set[i]) idx_d = IDX_W'(i);
  end

  // Free-running cycle counter and event timestamp capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
      ts_idx_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      if (|evt_set) begin
        ts_q     <= ts_cnt_q;
        ts_idx_q <= idx_d;
      end
    end
  end
`else
  logic unused_evt_set;
  assign unused_evt_set = ^evt_set;
`endif

  // Response for this cycle's request; reads see the register before any write.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (cfg.cfg_valid) begin
      if (cfg.cfg_addr < N_IO_A) begin
        if (!cfg.cfg_we) rdata_d = cfg_pack(rd_cfg);
`ifdef PAD_IN_FILTER_TIMESTAMP_EN
      end else if (cfg.cfg_addr == N_IO_A) begin
        if (!cfg.cfg_we) rdata_d = ts_q;
      end else if (cfg.cfg_addr == AW'(N_IO + 1)) begin
        if (!cfg.cfg_we) rdata_d = CFG_DW'(ts_idx_q);
`endif
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Registered response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= cfg.cfg_valid;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign cfg.cfg_rvalid = rvalid_q;
  assign cfg.cfg_rdata  = rdata_q;
  assign cfg.cfg_err    = err_q;

  for (genvar g = 0; g < N_IO; g++) begin : g_ch
    pad_in_filter_ch #(
      .FILT_W (FILT_W)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .pad_i     (pad_in_i[g]),
      .cfg_i     (cfg_q[g]),
      .cnt_clr_i (wr_sel[g]),
      .evt_clr_i (evt_clr_i[g]),
      .pad_o     (pad_in_o[g]),
      .evt_o     (evt_o[g]),
      .evt_set_o (evt_set[g])
    );
    assign irq_en[g] = cfg_q[g].irq_en;
  end

  assign irq_o = |(evt_o & irq_en);

endmodule

// File: tb/tb_pad_in_filter.sv
// Bench for pad_in_filter: time-based reference model, per-cycle compare, directed
// literal checks and a randomized phase.
module tb_pad_in_filter;
  import pad_in_filter_pkg::*;

  localparam int unsigned N  = 50;
  localparam int unsigned AW = $clog2(N + 1 + EXTRA_ADDRS);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pad_in = '0;
  logic [N-1:0] evt_clr = '0;
  logic [N-1:0] pad_out, evt;
  logic         irq;
  int           total = 0;
  int           bad = 0;

  pad_in_filter_if #(.AW(AW)) cfg_if ();

  pad_in_filter #(
    .N_IO   (N),
    .FILT_W (8),
    .AW     (AW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .pad_in_i  (pad_in),
    .pad_in_o  (pad_out),
    .evt_o     (evt),
    .evt_clr_i (evt_clr),
    .irq_o     (irq),
    .cfg       (cfg_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Filter rule in time terms: the level follows s2 once s2 has differed from it on
  // L+1 consecutive edges, counted from when that s2 value appeared or from the
  // edge after the last config write to the pad, whichever is later.
  bit          m_s1 [N], m_s2 [N], m_out [N], m_evt [N], m_chg [N];
  int          m_run [N], m_clr [N];
  logic [15:0] m_reg [N];
  bit          m_rvalid, m_err;
  logic [15:0] m_rdata, m_cyc, m_ts, m_idx;
  int          m_edge;
  int          ma, mfirst, mstart, mlen;
  logic        mv, mwe;
  logic [15:0] mwd;
  logic [1:0]  mmode;
  bit          mset;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_out[i] = 0; m_evt[i] = 0; m_chg[i] = 0;
        m_run[i] = 0; m_clr[i] = -1; m_reg[i] = '0;
      end
      m_rvalid = 0; m_err = 0; m_rdata = '0; m_cyc = '0; m_ts = '0; m_idx = '0;
      m_edge = 0;
    end else begin
      mv  = cfg_if.cfg_valid;
      mwe = cfg_if.cfg_we;
      ma  = int'(cfg_if.cfg_addr);
      mwd = cfg_if.cfg_wdata;
      // port response, from the registers as they were before this edge
      m_rvalid = mv; m_rdata = '0; m_err = 0;
      if (mv) begin
        if (ma < N) begin
          if (!mwe) m_rdata = m_reg[ma];
`ifdef PAD_IN_FILTER_TIMESTAMP_EN
        end else if (ma == N) begin
          if (!mwe) m_rdata = m_ts;
        end else if (ma == N + 1) begin
          if (!mwe) m_rdata = m_idx;
`endif
        end else begin
          m_err = 1;
        end
      end
      // events from level changes of the previous edge
      mfirst = -1;
      for (int i = 0; i < N; i++) begin
        mmode = m_reg[i][9:8];
        mset  = m_chg[i] && (mmode == 2'd3 || (mmode == 2'd1 && m_out[i]) ||
                             (mmode == 2'd2 && !m_out[i]));
        if (mset) begin
          m_evt[i] = 1;
          if (mfirst < 0) mfirst = i;
        end else if (evt_clr[i]) begin
          m_evt[i] = 0;
        end
      end
      if (mfirst >= 0) begin
        m_ts  = m_cyc;
        m_idx = 16'(mfirst);
      end
      m_cyc = m_cyc + 16'd1;
      // filter
      for (int i = 0; i < N; i++) begin
        m_chg[i] = 0;
        if (mv && mwe && ma == i) begin
          m_clr[i] = m_edge;
        end else begin
          mlen   = int'(m_reg[i][7:0]);
          mstart = (m_run[i] > m_clr[i] + 1) ? m_run[i] : m_clr[i] + 1;
          if (m_s2[i] != m_out[i] && m_edge - mstart >= mlen) begin
            m_out[i] = m_s2[i];
            m_chg[i] = 1;
          end
        end
        if (m_s1[i] != m_s2[i]) m_run[i] = m_edge + 1;
        m_s2[i] = m_s1[i];
        m_s1[i] = pad_in[i];
      end
      if (mv && mwe && ma < N) m_reg[ma] = mwd & 16'h07FF;
      m_edge++;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [N-1:0] c_out, c_evt, c_ien;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      c_out[i] = m_out[i];
      c_evt[i] = m_evt[i];
      c_ien[i] = m_reg[i][10];
    end
    chk("pad_in_o", 64'(pad_out), 64'(c_out));
    chk("evt_o", 64'(evt), 64'(c_evt));
    chk("irq_o", 64'(irq), 64'(|(c_evt & c_ien)));
    chk("cfg_rvalid", 64'(cfg_if.cfg_rvalid), 64'(m_rvalid));
    if (m_rvalid) begin
      chk("cfg_rdata", 64'(cfg_if.cfg_rdata), 64'(m_rdata));
      chk("cfg_err", 64'(cfg_if.cfg_err), 64'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    evt_clr = '0;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic cfg_acc(input logic we, input int addr, input logic [15:0] wd);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_we    = we;
    cfg_if.cfg_addr  = AW'(addr);
    cfg_if.cfg_wdata = wd;
    cyc();
  endtask

  logic [63:0] rmask;

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_we    = 1'b0;
    cfg_if.cfg_addr  = '0;
    cfg_if.cfg_wdata = '0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("reset pad_in_o", 64'(pad_out), 64'd0);
    chk("reset evt_o", 64'(evt), 64'd0);
    chk("reset irq_o", 64'(irq), 64'd0);
    chk("reset rdata/err", {cfg_if.cfg_rvalid, cfg_if.cfg_err, cfg_if.cfg_rdata}, 64'd0);

    // config port
    cfg_acc(1'b1, 2, 16'h0703);
    chk("write rvalid/rdata", {cfg_if.cfg_rvalid, cfg_if.cfg_rdata}, 64'h1_0000);
    cfg_acc(1'b0, 2, 16'h0000);
    chk("read addr2", {cfg_if.cfg_rvalid, cfg_if.cfg_err, cfg_if.cfg_rdata}, 64'h2_0703);
    cfg_acc(1'b0, 60, 16'h0000);
    chk("read addr60", {cfg_if.cfg_rvalid, cfg_if.cfg_err, cfg_if.cfg_rdata}, 64'h3_0000);
    cfg_acc(1'b1, 5, 16'hFFFF);
    cfg_acc(1'b0, 5, 16'h0000);
    chk("reserved bits", 64'(cfg_if.cfg_rdata), 64'h07FF);

    // deglitch, pad 3, L = 4
    cfg_acc(1'b1, 3, 16'h0004);
    pad_in[3] = 1'b1;
    repeat (4) cyc();
    pad_in[3] = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
        cyc();
        seen |= pad_out[3];
      end
      chk("4-cycle pulse rejected", 64'(seen), 64'd0);
    end
    pad_in[3] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      if (c == 5) pad_in[3] = 1'b0;
      if (c == 6) chk("5-cycle pulse at +6", 64'(pad_out[3]), 64'd0);
      if (c == 7) chk("5-cycle pulse at +7", 64'(pad_out[3]), 64'd1);
    end
    repeat (12) cyc();

    // edge mode both with irq_en, pad 7, L = 0
    cfg_acc(1'b1, 7, 16'h0700);
    pad_in[7] = 1'b1;
    repeat (3) cyc();
    chk("evt7 not yet", 64'(evt[7]), 64'd0);
    cyc();
    chk("evt7 after rise", 64'(evt[7]), 64'd1);
    chk("irq after rise", 64'(irq), 64'd1);
    pad_in[7] = 1'b0;
    repeat (3) cyc();
    evt_clr[7] = 1'b1;
    cyc();
    chk("set beats clear", 64'(evt[7]), 64'd1);
    evt_clr[7] = 1'b1;
    cyc();
    chk("evt7 cleared", 64'(evt[7]), 64'd0);
    chk("irq cleared", 64'(irq), 64'd0);

    // L = 0 latency on pad 0, then a mid-count write restarts the count
    pad_in[0] = 1'b1;
    repeat (2) cyc();
    chk("L0 +2", 64'(pad_out[0]), 64'd0);
    cyc();
    chk("L0 +3", 64'(pad_out[0]), 64'd1);
    cfg_acc(1'b1, 0, 16'h0003);
    pad_in[0] = 1'b0;
    repeat (4) cyc();
    cfg_acc(1'b1, 0, 16'h0001);
    cyc();
    chk("restart +6", 64'(pad_out[0]), 64'd1);
    cyc();
    chk("restart +7", 64'(pad_out[0]), 64'd0);

    // reset mid-operation: evt_o[0] pending, L = 5
    cfg_acc(1'b1, 0, 16'h0105);
    pad_in[0] = 1'b1;
    repeat (12) cyc();
    chk("evt0 before reset", 64'(evt[0]), 64'd1);
    pad_in = '0;
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", {irq, cfg_if.cfg_rvalid, cfg_if.cfg_err, 64'(evt | pad_out)},
        64'd0);
    repeat (2) cyc();
    rst = 1'b0;
    cfg_acc(1'b0, 0, 16'h0000);
    chk("cfg0 after reset", 64'(cfg_if.cfg_rdata), 64'd0);
    cfg_acc(1'b0, 2, 16'h0000);
    chk("cfg2 after reset", 64'(cfg_if.cfg_rdata), 64'd0);

`ifdef PAD_IN_FILTER_TIMESTAMP_EN
    // timestamp: simultaneous rises on pads 9 and 4 at counter 0x0123
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cfg_acc(1'b1, 9, 16'h0100);
    cfg_acc(1'b1, 4, 16'h0100);
    repeat (286) cyc();
    pad_in[9] = 1'b1;
    pad_in[4] = 1'b1;
    repeat (4) cyc();
    cfg_acc(1'b0, N, 16'h0000);
    chk("timestamp", {cfg_if.cfg_err, cfg_if.cfg_rdata}, 64'h0123);
    cfg_acc(1'b0, N + 1, 16'h0000);
    chk("ts pad index", {cfg_if.cfg_err, cfg_if.cfg_rdata}, 64'h0004);
`else
    cfg_acc(1'b0, N, 16'h0000);
    chk("addr N_IO err", {cfg_if.cfg_err, cfg_if.cfg_rdata}, 64'h1_0000);
`endif

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      rmask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} &
              {$urandom, $urandom};
      pad_in = pad_in ^ rmask[N-1:0];
      if ($urandom_range(0, 3) == 0) begin
        rmask   = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        evt_clr = rmask[N-1:0];
      end
      if ($urandom_range(0, 2) == 0) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_we    = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0)
          cfg_if.cfg_addr = AW'($urandom_range(N, (1 << AW) - 1));
        else
          cfg_if.cfg_addr = AW'($urandom_range(0, N - 1));
        cfg_if.cfg_wdata      = 16'($urandom);
        cfg_if.cfg_wdata[7:0] = 8'($urandom_range(0, 6));
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
